// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: synchronises reset deassertion, then releases a chain
// of subsystem resets one at a time, gated on each stage's ready flag, with timeout.
module reset_sequencer #(
  parameter int NUM_STAGES           = 4,
  parameter int SYNC_STAGES          = 2,
  parameter int STAGE_DELAY_CYCLES   = 1000,
  parameter int READY_TIMEOUT_CYCLES = 50000,
  localparam int FSW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  busy,
  output logic                  all_ready,
  output logic                  timeout_err,
  output logic [FSW-1:0]        fault_stage
);

  localparam int CW = $clog2(READY_TIMEOUT_CYCLES + 1);
  localparam int KW = FSW;

  localparam logic [CW-1:0] DELAY_M1 = CW'(STAGE_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] TMO_M1   = CW'(READY_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(READY_TIMEOUT_CYCLES);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_STAGE = 2'd1,
    DONE       = 2'd2,
    FAULT      = 2'd3
  } state_t;

  // Reset synchroniser: asserts with rst_n, deasserts SYNC_STAGES edges later
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  // Per-bit ready synchroniser
  logic [NUM_STAGES-1:0] rdy_sync [SYNC_STAGES];
  logic [NUM_STAGES-1:0] rdy_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rdy_sync[i] <= '0;
      end
    end else begin
      rdy_sync[0] <= stage_ready;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync[i] <= rdy_sync[i-1];
      end
    end
  end

  assign rdy_s = rdy_sync[SYNC_STAGES-1];

  state_t                state, state_nxt;
  logic [KW-1:0]         k, k_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] stage_rst_n_nxt;
  logic                  busy_nxt;
  logic                  all_ready_nxt;
  logic                  timeout_err_nxt;
  logic [FSW-1:0]        fault_stage_nxt;

  logic rdy_cur;
  logic advance;
  logic timeout;

  assign rdy_cur = rdy_s[k];
  assign advance = (cnt >= DELAY_M1) && rdy_cur;
  assign timeout = (cnt == TMO_M1) && !rdy_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      stage_rst_n <= '0;
      busy        <= 1'b0;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      cnt         <= cnt_nxt;
      stage_rst_n <= stage_rst_n_nxt;
      busy        <= busy_nxt;
      all_ready   <= all_ready_nxt;
      timeout_err <= timeout_err_nxt;
      fault_stage <= fault_stage_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    cnt_nxt         = cnt;
    stage_rst_n_nxt = stage_rst_n;
    busy_nxt        = busy;
    all_ready_nxt   = 1'b0;
    timeout_err_nxt = timeout_err;
    fault_stage_nxt = fault_stage;

    case (state)
      IDLE: begin
        if (rst_sync_n) begin
          state_nxt          = WAIT_STAGE;
          stage_rst_n_nxt[0] = 1'b1;
          k_nxt              = '0;
          cnt_nxt            = '0;
          busy_nxt           = 1'b1;
        end
      end

      WAIT_STAGE: begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        // Advance wins over timeout when both would fire in the same cycle
        if (advance) begin
          if (k < K_LAST) begin
            stage_rst_n_nxt[k + KW'(1)] = 1'b1;
            k_nxt                       = k + KW'(1);
            cnt_nxt                     = '0;
          end else begin
            state_nxt       = DONE;
            busy_nxt        = 1'b0;
            stage_rst_n_nxt = '1;
          end
        end else if (timeout) begin
          state_nxt          = FAULT;
          busy_nxt           = 1'b0;
          timeout_err_nxt    = 1'b1;
          fault_stage_nxt    = k;
          stage_rst_n_nxt[k] = 1'b0;
        end
      end

      DONE: begin
        all_ready_nxt = &rdy_s;
      end

      FAULT: begin
        cnt_nxt = cnt;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: table-driven nominal/ready-drop checks plus
// hand-written late-ready, timeout, simultaneous-event and mid-sequence reset cases.
module tb_reset_sequencer;

  localparam int NS = 3;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_rst_n;
  logic          busy;
  logic          all_ready;
  logic          timeout_err;
  logic [1:0]    fault_stage;

  reset_sequencer #(
    .NUM_STAGES          (3),
    .SYNC_STAGES         (2),
    .STAGE_DELAY_CYCLES  (8),
    .READY_TIMEOUT_CYCLES(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stage_ready(stage_ready),
    .stage_rst_n(stage_rst_n),
    .busy       (busy),
    .all_ready  (all_ready),
    .timeout_err(timeout_err),
    .fault_stage(fault_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    int         edge_n;
    logic [2:0] ready_after;
    logic [2:0] srst;
    logic       busy;
    logic       all_ready;
    logic       terr;
    logic [1:0] fs;
  } vec_t;

  vec_t vecs [15];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] srst, input logic b,
                         input logic ar, input logic te, input logic [1:0] fs);
    chk($sformatf("%s.stage_rst_n", tag), 32'(stage_rst_n), 32'(srst));
    chk($sformatf("%s.busy", tag), 32'(busy), 32'(b));
    chk($sformatf("%s.all_ready", tag), 32'(all_ready), 32'(ar));
    chk($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(te));
    chk($sformatf("%s.fault_stage", tag), 32'(fault_stage), 32'(fs));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic do_reset(input logic [2:0] rdy, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    stage_ready = rdy;
    #1;
    chk_out($sformatf("%s.in_reset", tag), 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_vecs(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      run_to(vecs[i].edge_n);
      chk_out($sformatf("%s.e%0d", tag, vecs[i].edge_n), vecs[i].srst, vecs[i].busy,
              vecs[i].all_ready, vecs[i].terr, vecs[i].fs);
      stage_ready = vecs[i].ready_after;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    stage_ready = '0;

    // Nominal sequence, ready constant 111
    vecs[0]  = '{2,  3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{3,  3'b111, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{10, 3'b111, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{11, 3'b111, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{18, 3'b111, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{19, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{26, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{27, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{28, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0};
    // Ready[1] drop in DONE: dropped after edge 30, restored after edge 40
    vecs[9]  = '{30, 3'b101, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{32, 3'b101, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{33, 3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{40, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[13] = '{42, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{43, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0};

    // Nominal sequence followed by ready drop in DONE
    do_reset(3'b111, "nom");
    run_vecs(0, 8, "nom");
    run_vecs(9, 14, "drop");

    // Late ready on stage 1: rises after edge 31, stage 2 released at edge 34
    do_reset(3'b101, "late");
    run_to(31);
    chk_out("late.e31", 3'b011, 1'b1, 1'b0, 1'b0, 2'd0);
    stage_ready = 3'b111;
    run_to(33);
    chk_out("late.e33", 3'b011, 1'b1, 1'b0, 1'b0, 2'd0);
    run_to(34);
    chk_out("late.e34", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
    run_to(42);
    chk_out("late.e42", 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    run_to(43);
    chk_out("late.e43", 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);

    // Timeout on stage 2: released at edge 19, fault at edge 51
    do_reset(3'b011, "tmo");
    run_to(50);
    chk_out("tmo.e50", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
    run_to(51);
    chk_out("tmo.e51", 3'b011, 1'b0, 1'b0, 1'b1, 2'd2);
    stage_ready = 3'b111;
    run_to(151);
    chk_out("tmo.hold", 3'b011, 1'b0, 1'b0, 1'b1, 2'd2);

    // Simultaneous: rdy_s[0] rises at edge 34 where cnt becomes 31
    do_reset(3'b110, "sim");
    run_to(32);
    stage_ready = 3'b111;
    run_to(34);
    chk_out("sim.e34", 3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
    run_to(35);
    chk_out("sim.e35", 3'b011, 1'b1, 1'b0, 1'b0, 2'd0);

    // One cycle too late: stage 0 times out at edge 35
    do_reset(3'b110, "late0");
    run_to(33);
    stage_ready = 3'b111;
    run_to(35);
    chk_out("late0.e35", 3'b000, 1'b0, 1'b0, 1'b1, 2'd0);

    // Reset asserted mid-sequence, then nominal timing repeats
    do_reset(3'b111, "mid");
    run_to(12);
    chk_out("mid.e12", 3'b011, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("mid.async", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    do_reset(3'b111, "mid2");
    run_vecs(0, 8, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
